arcade_input_mapper: RTL and testbench
======================================

Name: arcade_input_mapper

Overview:
Parametrised successor to the per-core keyboard/joystick glue in the arcade top level. Decodes PS/2 key events and per-player joystick words into active-high control strobes for up to 4 players. Applies one of four screen-rotation remaps, plus a cocktail 180° flip for players ≥1. Stretches coin inputs to a fixed pulse width and, when compiled in, runs an auto-coin sequencer that converts a start press into coin → gap → start pulses. Sits between hps_io and the game core's I_U1/I_C1-style inputs.

Parameters:
PLAYERS, 2, number of player channels, legal 1..4
COIN_PULSE, 2457600, coin/start pulse width in clock cycles (100 ms at 24.576 MHz), ≥1
COIN_GAP, 2457600, idle cycles between auto-coin pulse and auto-start pulse, ≥1

Ports:
I_CLK  in  1  system clock; every register is clocked by this edge
I_RESETn  in  1  asynchronous, active-low reset
I_PS2_KEY  in  11  [10] toggle strobe, [9] pressed, [8] extended, [7:0] scan code
I_JOY  in  16*PLAYERS  per player: [0]R [1]L [2]D [3]U [4]fire [5]start [6]coin
I_ROT  in  2  0 none, 1 rot90, 2 rot180, 3 rot270
I_COCKTAIL  in  1  1: players ≥1 get an extra 180° remap
O_U, O_D, O_L, O_R, O_J  out  PLAYERS each  direction and fire strobes, active high
O_START  out  PLAYERS  start strobes
O_COIN  out  1  coin strobe, stretched
O_BUSY  out  1  auto-coin sequencer not IDLE

Behaviour:
- Reset: every key latch, counter and output is 0; FSM in IDLE. Reset mid-sequence aborts at once. No pulse resumes after release.
- Key decode:
  - Register old toggle.
  - When I_PS2_KEY[10] differs from old toggle, latch pressed into the matching key.
  - Player 0 keys: E0 75/72/6B/74 give U/D/L/R. 029 and 014 give fire. 005 and 016 give start0. 006 and 01E give start1.
  - Player 1 keys: 02D/02B/023/034 give U/D/L/R. 01C gives fire.
  - Coin keys: 02E and 036.
  - Players 2..3 have no keys.
  - Any other code is ignored.
- Raw per-player signals = key latch OR I_JOY bit.
- Rotation, with effective rot = I_ROT + (I_COCKTAIL && p≥1 ? 2 : 0) mod 4:
  - rot1: U←L, D←R, L←D, R←U.
  - rot2: U←D, D←U, L←R, R←L.
  - rot3: U←R, D←L, L←U, R←D.
  - Fire is never remapped.
- Latency: all outputs are registered.
  - Direction/fire outputs reflect a key event 2 cycles after the toggle edge.
  - They reflect a joystick change 1 cycle after it.
- Coin stretcher: a rising edge of (coin keys OR any I_JOY[6]) loads a counter with COIN_PULSE.
  - The stretched coin is high while the counter is nonzero.
  - A new rising edge during the pulse reloads the counter, so the pulse is extended.
  - O_COIN = stretched coin OR FSM coin.
- Auto-coin FSM (states IDLE, COIN, GAP, START):
  - Each player start request is rising-edge detected.
  - IDLE: on an edge, capture the lowest-index requesting player as sel. Load COIN_PULSE and go to COIN.
  - COIN: FSM coin high. Count down; at 1, load COIN_GAP and go to GAP.
  - GAP: all FSM outputs low. At count 1, load COIN_PULSE and go to START.
  - START: O_START[sel] high. At count 1, go to IDLE.
  - Start edges arriving outside IDLE are dropped, with no queueing.
  - O_BUSY = (state != IDLE).
  - Exact widths: COIN high exactly COIN_PULSE cycles, gap exactly COIN_GAP cycles, start exactly COIN_PULSE cycles.
- Counter width: clog2 of max(COIN_PULSE, COIN_GAP) plus 1; no wrap is permitted.

Optional Feature:
AUTO_COIN_EN
- Defined: the FSM is present as described above.
- Undefined:
  - FSM removed; O_BUSY is tied 0.
  - O_START[p] = registered raw start (level, not pulsed).
  - O_COIN = stretched coin only.

Test Plan:
- Reset, then key toggle with code 0x175 pressed → O_U[0]=1 two cycles later; toggle again with pressed=0 → O_U[0]=0.
- I_ROT=1, I_JOY[1]=1 → O_U[0]=1, O_L[0]=0; I_ROT=3, same input → O_D[0]=1.
- I_COCKTAIL=1, I_ROT=0, I_JOY[16+3]=1 → O_D[1]=1; player 0 unaffected.
- COIN_PULSE=4, coin key 02E pressed → O_COIN high exactly 4 cycles; a re-press on the third high cycle extends it to 4 cycles after the re-press.
- AUTO_COIN_EN, COIN_PULSE=4, COIN_GAP=3, start0 edge → O_COIN 4 cycles, 3 low, O_START[0] 4 cycles, O_BUSY high throughout; a start1 edge during GAP is dropped.
- Assert I_RESETn low during START → all outputs 0 immediately; after release O_BUSY=0 and no pulse resumes.

Source files
------------

// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: turns PS/2 key events and per-player joystick words into
// active-high, registered control strobes for up to four players. It applies
// screen rotation and a cocktail flip, stretches coin pulses, and optionally
// runs an auto-coin sequencer (coin -> gap -> start).
//
// Optional feature macro: AUTO_COIN_EN
//   defined   : auto-coin FSM present, O_START pulsed by the FSM, O_BUSY live
//   undefined : O_START is the registered raw start level, O_BUSY tied 0
//
// Ports:
//   I_CLK       system clock
//   I_RESETn    asynchronous active-low reset
//   I_PS2_KEY   [10] toggle, [9] pressed, [8] extended, [7:0] scan code
//   I_JOY       16 bits per player: [0]R [1]L [2]D [3]U [4]fire [5]start [6]coin
//   I_ROT       0 none, 1 rot90, 2 rot180, 3 rot270
//   I_COCKTAIL  extra 180 degree remap for players >= 1
//   O_U/D/L/R/J direction and fire strobes per player
//   O_START     start strobes per player
//   O_COIN      stretched coin strobe
//   O_BUSY      auto-coin sequencer active
module arcade_input_mapper #(
    parameter int unsigned PLAYERS    = 2,
    parameter int unsigned COIN_PULSE = 2457600,
    parameter int unsigned COIN_GAP   = 2457600
) (
    input  logic                   I_CLK,
    input  logic                   I_RESETn,
    input  logic [10:0]            I_PS2_KEY,
    input  logic [16*PLAYERS-1:0]  I_JOY,
    input  logic [1:0]             I_ROT,
    input  logic                   I_COCKTAIL,
    output logic [PLAYERS-1:0]     O_U,
    output logic [PLAYERS-1:0]     O_D,
    output logic [PLAYERS-1:0]     O_L,
    output logic [PLAYERS-1:0]     O_R,
    output logic [PLAYERS-1:0]     O_J,
    output logic [PLAYERS-1:0]     O_START,
    output logic                   O_COIN,
    output logic                   O_BUSY
);

    localparam int unsigned CNT_MAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
    localparam int unsigned CW      = $clog2(CNT_MAX) + 1;
    localparam int unsigned NKEYS   = 17;

    // Key latch slots
    localparam int unsigned K_P0U = 0,  K_P0D = 1,  K_P0L = 2,  K_P0R = 3;
    localparam int unsigned K_F0A = 4,  K_F0B = 5,  K_S0A = 6,  K_S0B = 7;
    localparam int unsigned K_S1A = 8,  K_S1B = 9,  K_P1U = 10, K_P1D = 11;
    localparam int unsigned K_P1L = 12, K_P1R = 13, K_F1  = 14, K_C0  = 15;
    localparam int unsigned K_C1  = 16;

    // Direction vectors are {U, D, L, R}, the same order as I_JOY[3:0].
    function automatic logic [3:0] map_dir(input logic [3:0] d, input logic [1:0] rot);
        logic [3:0] r;
        case (rot)
            2'd1:    r = {d[1], d[0], d[2], d[3]};
            2'd2:    r = {d[2], d[3], d[0], d[1]};
            2'd3:    r = {d[0], d[1], d[3], d[2]};
            default: r = d;
        endcase
        return r;
    endfunction

    logic [NKEYS-1:0] key_hit_c;
    logic [NKEYS-1:0] keys_q;
    logic             toggle_q;

    // Scan code (with extended flag) to key slot
    always_comb begin
        key_hit_c = '0;
        case (I_PS2_KEY[8:0])
            9'h175: key_hit_c[K_P0U] = 1'b1;
            9'h172: key_hit_c[K_P0D] = 1'b1;
            9'h16B: key_hit_c[K_P0L] = 1'b1;
            9'h174: key_hit_c[K_P0R] = 1'b1;
            9'h029: key_hit_c[K_F0A] = 1'b1;
            9'h014: key_hit_c[K_F0B] = 1'b1;
            9'h005: key_hit_c[K_S0A] = 1'b1;
            9'h016: key_hit_c[K_S0B] = 1'b1;
            9'h006: key_hit_c[K_S1A] = 1'b1;
            9'h01E: key_hit_c[K_S1B] = 1'b1;
            9'h02D: key_hit_c[K_P1U] = 1'b1;
            9'h02B: key_hit_c[K_P1D] = 1'b1;
            9'h023: key_hit_c[K_P1L] = 1'b1;
            9'h034: key_hit_c[K_P1R] = 1'b1;
            9'h01C: key_hit_c[K_F1]  = 1'b1;
            9'h02E: key_hit_c[K_C0]  = 1'b1;
            9'h036: key_hit_c[K_C1]  = 1'b1;
            default: ;
        endcase
    end

    // Key latches: a toggle change writes the pressed flag into the decoded slot
    always_ff @(posedge I_CLK or negedge I_RESETn) begin
        if (!I_RESETn) begin
            toggle_q <= 1'b0;
            keys_q   <= '0;
        end else begin
            toggle_q <= I_PS2_KEY[10];
            if (I_PS2_KEY[10] != toggle_q)
                keys_q <= (keys_q & ~key_hit_c) | (key_hit_c & {NKEYS{I_PS2_KEY[9]}});
        end
    end

    logic [3:0][3:0] kdir_c;
    logic [3:0]      kfire_c;
    logic [3:0]      kstart_c;

    assign kdir_c[0] = {keys_q[K_P0U], keys_q[K_P0D], keys_q[K_P0L], keys_q[K_P0R]};
    assign kdir_c[1] = {keys_q[K_P1U], keys_q[K_P1D], keys_q[K_P1L], keys_q[K_P1R]};
    assign kdir_c[2] = 4'b0000;
    assign kdir_c[3] = 4'b0000;
    assign kfire_c   = {2'b00, keys_q[K_F1], keys_q[K_F0A] | keys_q[K_F0B]};
    assign kstart_c  = {2'b00, keys_q[K_S1A] | keys_q[K_S1B], keys_q[K_S0A] | keys_q[K_S0B]};

    // Joystick high bits and key slots of absent players are intentionally ignored
    logic unused_sink;
    assign unused_sink = ^{I_JOY, kdir_c, kfire_c, kstart_c};

    logic [PLAYERS-1:0][3:0] dir_c;
    logic [PLAYERS-1:0]      u_c, d_c, l_c, r_c, fire_c, start_raw_c;
    logic                    coin_joy_c;

    // Per-player merge of keys and joystick, then rotation (cocktail adds 180)
    always_comb begin
        dir_c       = '0;
        u_c         = '0;
        d_c         = '0;
        l_c         = '0;
        r_c         = '0;
        fire_c      = '0;
        start_raw_c = '0;
        coin_joy_c  = 1'b0;
        for (int p = 0; p < PLAYERS; p++) begin
            dir_c[p] = map_dir(I_JOY[16*p +: 4] | kdir_c[p],
                               I_ROT + ((I_COCKTAIL && (p >= 1)) ? 2'd2 : 2'd0));
            u_c[p]         = dir_c[p][3];
            d_c[p]         = dir_c[p][2];
            l_c[p]         = dir_c[p][1];
            r_c[p]         = dir_c[p][0];
            fire_c[p]      = I_JOY[16*p + 4] | kfire_c[p];
            start_raw_c[p] = I_JOY[16*p + 5] | kstart_c[p];
            coin_joy_c     = coin_joy_c | I_JOY[16*p + 6];
        end
    end

    logic          coin_raw_c;
    logic          coin_raw_q;
    logic [CW-1:0] coin_cnt_q;
    logic          stretch_c;

    assign coin_raw_c = keys_q[K_C0] | keys_q[K_C1] | coin_joy_c;
    assign stretch_c  = (coin_cnt_q != '0);

    // Coin stretcher: each rising edge (re)loads the pulse counter
    always_ff @(posedge I_CLK or negedge I_RESETn) begin
        if (!I_RESETn) begin
            coin_raw_q <= 1'b0;
            coin_cnt_q <= '0;
        end else begin
            coin_raw_q <= coin_raw_c;
            if (coin_raw_c && !coin_raw_q)
                coin_cnt_q <= CW'(COIN_PULSE);
            else if (coin_cnt_q != '0)
                coin_cnt_q <= coin_cnt_q - CW'(1);
        end
    end

`ifdef AUTO_COIN_EN
    typedef enum logic [1:0] {ST_IDLE, ST_COIN, ST_GAP, ST_START} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      fsm_cnt_q, fsm_cnt_d;
    logic [1:0]         sel_q, sel_d, sel_pick_c;
    logic [PLAYERS-1:0] start_q, start_rise_c, start_sel_c;

    assign start_rise_c = start_raw_c & ~start_q;

    // Lowest-index requesting player wins
    always_comb begin
        sel_pick_c = 2'd0;
        for (int p = PLAYERS - 1; p >= 0; p--)
            if (start_rise_c[p]) sel_pick_c = 2'(p);
    end

    always_ff @(posedge I_CLK or negedge I_RESETn) begin
        if (!I_RESETn) begin
            state_q   <= ST_IDLE;
            fsm_cnt_q <= '0;
            sel_q     <= 2'd0;
            start_q   <= '0;
        end else begin
            state_q   <= state_d;
            fsm_cnt_q <= fsm_cnt_d;
            sel_q     <= sel_d;
            start_q   <= start_raw_c;
        end
    end

    // Sequencer: start edges are only accepted in IDLE, never queued
    always_comb begin
        state_d   = state_q;
        fsm_cnt_d = fsm_cnt_q;
        sel_d     = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (|start_rise_c) begin
                    sel_d     = sel_pick_c;
                    fsm_cnt_d = CW'(COIN_PULSE);
                    state_d   = ST_COIN;
                end
            end
            ST_COIN: begin
                if (fsm_cnt_q == CW'(1)) begin
                    fsm_cnt_d = CW'(COIN_GAP);
                    state_d   = ST_GAP;
                end else begin
                    fsm_cnt_d = fsm_cnt_q - CW'(1);
                end
            end
            ST_GAP: begin
                if (fsm_cnt_q == CW'(1)) begin
                    fsm_cnt_d = CW'(COIN_PULSE);
                    state_d   = ST_START;
                end else begin
                    fsm_cnt_d = fsm_cnt_q - CW'(1);
                end
            end
            default: begin
                if (fsm_cnt_q == CW'(1)) begin
                    fsm_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    fsm_cnt_d = fsm_cnt_q - CW'(1);
                end
            end
        endcase
    end

    always_comb begin
        start_sel_c = '0;
        for (int p = 0; p < PLAYERS; p++)
            start_sel_c[p] = (state_q == ST_START) && (sel_q == 2'(p));
    end

    always_ff @(posedge I_CLK or negedge I_RESETn) begin
        if (!I_RESETn) O_BUSY <= 1'b0;
        else           O_BUSY <= (state_q != ST_IDLE);
    end
`else
    assign O_BUSY = 1'b0;
`endif

    // Output registers
    always_ff @(posedge I_CLK or negedge I_RESETn) begin
        if (!I_RESETn) begin
            O_U     <= '0;
            O_D     <= '0;
            O_L     <= '0;
            O_R     <= '0;
            O_J     <= '0;
            O_START <= '0;
            O_COIN  <= 1'b0;
        end else begin
            O_U <= u_c;
            O_D <= d_c;
            O_L <= l_c;
            O_R <= r_c;
            O_J <= fire_c;
`ifdef AUTO_COIN_EN
            O_START <= start_sel_c;
            O_COIN  <= stretch_c | (state_q == ST_COIN);
`else
            O_START <= start_raw_c;
            O_COIN  <= stretch_c;
`endif
        end
    end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Bench for arcade_input_mapper: directed scenarios plus randomized stimulus,
// all checked every cycle against a timeline-based reference model.
module tb_arcade_input_mapper;

    localparam int unsigned PLAYERS = 3;
    localparam int unsigned CP      = 4;
    localparam int unsigned CG      = 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [10:0]           ps2;
    logic [16*PLAYERS-1:0] joy;
    logic [1:0]            rot;
    logic                  cocktail;
    logic [PLAYERS-1:0]    o_u, o_d, o_l, o_r, o_j, o_start;
    logic                  o_coin, o_busy;

    arcade_input_mapper #(.PLAYERS(PLAYERS), .COIN_PULSE(CP), .COIN_GAP(CG)) dut (
        .I_CLK(clk), .I_RESETn(rst_n), .I_PS2_KEY(ps2), .I_JOY(joy),
        .I_ROT(rot), .I_COCKTAIL(cocktail),
        .O_U(o_u), .O_D(o_d), .O_L(o_l), .O_R(o_r), .O_J(o_j),
        .O_START(o_start), .O_COIN(o_coin), .O_BUSY(o_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state
    bit mkey [int];
    bit prev_toggle;
    bit [PLAYERS-1:0] prev_start;
    bit prev_coin;
    int coin_rises [$];
    bit seq_valid;
    int seq_t0;
    int seq_sel;

    // Compass order U, R, D, L: rotation by n means out[i] = in[i - n]
    int dir_code [2][4] = '{'{32'h175, 32'h174, 32'h172, 32'h16B},
                            '{32'h02D, 32'h034, 32'h02B, 32'h023}};
    int jbit [4] = '{3, 0, 2, 1};

    int cnt_coin, cnt_busy;
    int cnt_start [PLAYERS];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit key(input int code);
        return mkey.exists(code) ? mkey[code] : 1'b0;
    endfunction

    task automatic press(input logic [8:0] code, input logic dn);
        ps2 = {~ps2[10], dn, code};
    endtask

    task automatic clear_counts();
        cnt_coin = 0;
        cnt_busy = 0;
        for (int p = 0; p < PLAYERS; p++) cnt_start[p] = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_u"}, 32'(o_u), 0);
        check({tag, "_d"}, 32'(o_d), 0);
        check({tag, "_l"}, 32'(o_l), 0);
        check({tag, "_r"}, 32'(o_r), 0);
        check({tag, "_j"}, 32'(o_j), 0);
        check({tag, "_start"}, 32'(o_start), 0);
        check({tag, "_coin"}, 32'(o_coin), 0);
        check({tag, "_busy"}, 32'(o_busy), 0);
    endtask

    // One clock: predict outputs for the coming edge, apply key event, compare
    task automatic step();
        int k;
        bit in_c [4];
        bit out_c [4];
        int effrot;
        logic [PLAYERS-1:0] eu, ed, el, er, ej, es;
        bit [PLAYERS-1:0] sraw, rise;
        bit coin_raw, stretch, ecoin, ebusy, fcoin;
        k = cyc + 1;
        eu = '0; ed = '0; el = '0; er = '0; ej = '0; es = '0;
        sraw = '0; coin_raw = key(32'h02E) | key(32'h036);
        for (int p = 0; p < PLAYERS; p++) begin
            for (int i = 0; i < 4; i++) begin
                in_c[i] = joy[16*p + jbit[i]];
                if (p < 2) in_c[i] = in_c[i] | key(dir_code[p][i]);
            end
            effrot = (int'(rot) + ((cocktail && p >= 1) ? 2 : 0)) % 4;
            for (int i = 0; i < 4; i++) out_c[i] = in_c[(i - effrot + 4) % 4];
            eu[p] = out_c[0]; er[p] = out_c[1]; ed[p] = out_c[2]; el[p] = out_c[3];
            ej[p]   = joy[16*p + 4];
            sraw[p] = joy[16*p + 5];
            if (p == 0) begin
                ej[p]   = ej[p] | key(32'h029) | key(32'h014);
                sraw[p] = sraw[p] | key(32'h005) | key(32'h016);
            end else if (p == 1) begin
                ej[p]   = ej[p] | key(32'h01C);
                sraw[p] = sraw[p] | key(32'h006) | key(32'h01E);
            end
            coin_raw = coin_raw | joy[16*p + 6];
        end
        // Each coin rise at edge r gives a high window on observations r+1 .. r+CP
        if (coin_raw && !prev_coin) coin_rises.push_back(k);
        prev_coin = coin_raw;
        while (coin_rises.size() > 0 && coin_rises[0] + int'(CP) < k) void'(coin_rises.pop_front());
        stretch = 0;
        foreach (coin_rises[i])
            if (k >= coin_rises[i] + 1 && k <= coin_rises[i] + int'(CP)) stretch = 1;
`ifdef AUTO_COIN_EN
        rise = sraw & ~prev_start;
        if (rise != 0 && (!seq_valid || k >= seq_t0 + int'(2*CP + CG) + 1)) begin
            seq_valid = 1;
            seq_t0    = k;
            for (int p = PLAYERS - 1; p >= 0; p--) if (rise[p]) seq_sel = p;
        end
        ebusy = seq_valid && k >= seq_t0 + 1 && k <= seq_t0 + int'(2*CP + CG);
        fcoin = seq_valid && k >= seq_t0 + 1 && k <= seq_t0 + int'(CP);
        if (seq_valid && k >= seq_t0 + int'(CP + CG) + 1 && k <= seq_t0 + int'(2*CP + CG))
            es[seq_sel] = 1'b1;
        ecoin = stretch | fcoin;
`else
        rise  = '0;
        fcoin = 0;
        es    = sraw;
        ebusy = 0;
        ecoin = stretch;
`endif
        prev_start = sraw;
        if (ps2[10] != prev_toggle) mkey[int'(ps2[8:0])] = ps2[9];
        prev_toggle = ps2[10];
        @(posedge clk);
        #1;
        cyc = k;
        check("O_U", 32'(o_u), 32'(eu));
        check("O_D", 32'(o_d), 32'(ed));
        check("O_L", 32'(o_l), 32'(el));
        check("O_R", 32'(o_r), 32'(er));
        check("O_J", 32'(o_j), 32'(ej));
        check("O_START", 32'(o_start), 32'(es));
        check("O_COIN", 32'(o_coin), 32'(ecoin));
        check("O_BUSY", 32'(o_busy), 32'(ebusy));
        cnt_coin += int'(o_coin);
        cnt_busy += int'(o_busy);
        for (int p = 0; p < PLAYERS; p++) cnt_start[p] += int'(o_start[p]);
    endtask

    task automatic do_reset(input bit check_now);
        rst_n = 1'b0;
        #1;
        if (check_now) check_all_zero("rst_async");
        mkey.delete();
        coin_rises.delete();
        prev_toggle = 0;
        prev_start  = '0;
        prev_coin   = 0;
        seq_valid   = 0;
        repeat (2) @(posedge clk);
        #1;
        cyc += 2;
        check_all_zero("rst_hold");
        rst_n = 1'b1;
    endtask

    initial begin
        ps2 = '0; joy = '0; rot = 2'd0; cocktail = 1'b0;
        clear_counts();
        do_reset(1'b0);

        // Key decode latency and release
        press(9'h175, 1'b1);
        step();
        step();
        check("key_u_press", 32'(o_u[0]), 1);
        press(9'h175, 1'b0);
        step();
        step();
        check("key_u_release", 32'(o_u[0]), 0);

        // Rotation on joystick input
        rot = 2'd1; joy[1] = 1'b1;
        step();
        check("rot1_u", 32'(o_u[0]), 1);
        check("rot1_l", 32'(o_l[0]), 0);
        rot = 2'd3;
        step();
        check("rot3_d", 32'(o_d[0]), 1);

        // Cocktail flips player 1 only
        rot = 2'd0; cocktail = 1'b1; joy = '0;
        joy[16+3] = 1'b1; joy[3] = 1'b1;
        step();
        check("cocktail_d1", 32'(o_d[1]), 1);
        check("cocktail_u1", 32'(o_u[1]), 0);
        check("cocktail_u0", 32'(o_u[0]), 1);
        joy = '0; cocktail = 1'b0;
        step();
        step();

        // Coin stretch: single press, then a re-press during the pulse
        clear_counts();
        press(9'h02E, 1'b1);
        repeat (8) step();
        check("coin_width", 32'(cnt_coin), CP);
        press(9'h02E, 1'b0);
        repeat (2) step();
        clear_counts();
        press(9'h02E, 1'b1);
        step();
        press(9'h02E, 1'b0);
        step();
        step();
        press(9'h02E, 1'b1);
        repeat (10) step();
        check("coin_extend", 32'(cnt_coin), 7);
        press(9'h02E, 1'b0);
        repeat (2) step();

        // Auto-coin sequence; a player-1 start during the gap is dropped
        clear_counts();
        press(9'h005, 1'b1);
        repeat (6) step();
        joy[16+5] = 1'b1;
        repeat (12) step();
`ifdef AUTO_COIN_EN
        check("auto_coin", 32'(cnt_coin), CP);
        check("auto_start0", 32'(cnt_start[0]), CP);
        check("auto_start1", 32'(cnt_start[1]), 0);
        check("auto_busy", 32'(cnt_busy), 2*CP + CG);
`endif
        press(9'h005, 1'b0);
        joy = '0;
        repeat (3) step();

        // Reset while the start pulse is out
        joy[5] = 1'b1;
        step();
        joy[5] = 1'b0;
        repeat (8) step();
`ifdef AUTO_COIN_EN
        check("in_start", 32'(o_start[0]), 1);
`endif
        do_reset(1'b1);
        clear_counts();
        repeat (15) step();
        check("post_rst_busy", 32'(cnt_busy), 0);
        check("post_rst_coin", 32'(cnt_coin), 0);
        check("post_rst_start", 32'(cnt_start[0] + cnt_start[1]), 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int p;
            int b;
            int idx;
            logic [8:0] code;
            if ($urandom_range(0, 3) == 0) begin
                p = $urandom_range(0, PLAYERS - 1);
                b = $urandom_range(0, 15);
                if ($urandom_range(0, 1) == 0) b = $urandom_range(0, 6);
                joy[16*p + b] = ~joy[16*p + b];
            end
            if ($urandom_range(0, 3) == 0) begin
                idx = $urandom_range(0, 19);
                case (idx)
                    0: code = 9'h175;  1: code = 9'h172;  2: code = 9'h16B;
                    3: code = 9'h174;  4: code = 9'h029;  5: code = 9'h014;
                    6: code = 9'h005;  7: code = 9'h016;  8: code = 9'h006;
                    9: code = 9'h01E; 10: code = 9'h02D; 11: code = 9'h02B;
                   12: code = 9'h023; 13: code = 9'h034; 14: code = 9'h01C;
                   15: code = 9'h02E; 16: code = 9'h036; 17: code = 9'h075;
                   default: code = 9'($urandom_range(0, 511));
                endcase
                press(code, 1'($urandom_range(0, 1)));
            end else if ($urandom_range(0, 7) == 0) begin
                ps2[9:0] = 10'($urandom_range(0, 1023));
            end
            if ($urandom_range(0, 49) == 0) rot = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 79) == 0) cocktail = ~cocktail;
            if ($urandom_range(0, 699) == 0) do_reset(1'b1);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
